// File: rtl/jtdsp16_fetch_if.sv
// Fetch-stage bus: program address/ROM word, do/redo loop decode, and the
// instruction register outputs towards the decoder and the ROM AAU.
interface jtdsp16_fetch_if #(
    parameter int CW = 4
);
    logic [15:0]   pc;
    logic [15:0]   rom_addr;
    logic [15:0]   rom_data;
    logic          do_start;
    logic [CW-1:0] do_ni;
    logic [6:0]    do_k;
    logic          redo_start;
    logic          flush;
    logic [15:0]   ir;
    logic          ir_valid;
    logic          pc_hold;
    logic          cache_busy;

    modport master (
        output pc, rom_data, do_start, do_ni, do_k, redo_start, flush,
        input  rom_addr, ir, ir_valid, pc_hold, cache_busy
    );

    modport slave (
        input  pc, rom_data, do_start, do_ni, do_k, redo_start, flush,
        output rom_addr, ir, ir_valid, pc_hold, cache_busy
    );
endinterface

// File: rtl/jtdsp16_fetch.sv
// DSP16 instruction fetch with the do-K loop cache (fill on first pass, replay after).
// Optional JTDSP16_REDO_EN: redo K replays the cached body without a fill pass.
module jtdsp16_fetch #(
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    jtdsp16_fetch_if.slave bus
);
    localparam int DEPTH = (1 << CW) - 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY
    } state_t;

    state_t        state;
    logic [15:0]   cache [DEPTH];
    logic [CW-1:0] n_st;
    logic [CW-1:0] idx;
    logic [CW-1:0] n_last;
    logic [6:0]    iter;
    logic          last;
    logic          fill_we;

    assign bus.rom_addr   = bus.pc;
    assign bus.pc_hold    = (state == REPLAY);
    assign bus.cache_busy = (state != IDLE);

    assign n_last  = n_st - CW'(1);
    assign last    = (idx == n_last);
    assign fill_we = cen && !rst && !bus.flush && (state == FILL);

    // Cache RAM carries no reset so it can map onto a plain memory
    always_ff @(posedge clk) begin
        if (fill_we) begin
            cache[idx] <= bus.rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.ir       <= '0;
            bus.ir_valid <= 1'b0;
            n_st         <= '0;
            iter         <= '0;
            idx          <= '0;
        end else if (cen) begin
            if (bus.flush) begin
                state        <= IDLE;
                bus.ir_valid <= 1'b0;
                idx          <= '0;
                // An aborted fill keeps only the words that reached the cache
                if (state == FILL) begin
                    n_st <= idx;
                end
            end else begin
                case (state)
                    IDLE: begin
                        bus.ir       <= bus.rom_data;
                        bus.ir_valid <= 1'b1;
                        if (bus.do_start) begin
                            if (bus.do_ni != '0 && bus.do_k != '0) begin
                                n_st  <= bus.do_ni;
                                iter  <= bus.do_k;
                                idx   <= '0;
                                state <= FILL;
                            end
                        end
`ifdef JTDSP16_REDO_EN
                        else if (bus.redo_start && n_st != '0 && bus.do_k != '0) begin
                            iter  <= bus.do_k;
                            idx   <= '0;
                            state <= REPLAY;
                        end
`endif
                    end

                    FILL: begin
                        bus.ir       <= bus.rom_data;
                        bus.ir_valid <= 1'b1;
                        if (last) begin
                            idx <= '0;
                            if (iter == 7'd1) begin
                                state <= IDLE;
                            end else begin
                                iter  <= iter - 7'd1;
                                state <= REPLAY;
                            end
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end

                    REPLAY: begin
                        bus.ir       <= cache[idx];
                        bus.ir_valid <= 1'b1;
                        if (last) begin
                            idx <= '0;
                            if (iter == 7'd1) begin
                                state <= IDLE;
                            end else begin
                                iter <= iter - 7'd1;
                            end
                        end else begin
                            idx <= idx + CW'(1);
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtdsp16_fetch.sv
// Directed bench for jtdsp16_fetch; ROM word = address ^ 16'hA5A5.
// Build with JTDSP16_REDO_EN defined to exercise the redo path.
module tb_jtdsp16_fetch;
    logic clk;
    logic rst;
    logic cen;
    int   checks;
    int   failures;

    jtdsp16_fetch_if #(.CW(4)) bus ();

    jtdsp16_fetch #(.CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    assign bus.rom_data = bus.rom_addr ^ 16'hA5A5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout ran past time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] rom_word(input int a);
        return 16'(a) ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] ir_e, input logic v_e,
                              input logic hold_e, input logic busy_e);
        chk({tag, ".ir"}, 32'(bus.ir), 32'(ir_e));
        chk({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(v_e));
        chk({tag, ".pc_hold"}, 32'(bus.pc_hold), 32'(hold_e));
        chk({tag, ".cache_busy"}, 32'(bus.cache_busy), 32'(busy_e));
    endtask

    // One cen cycle preceded by two frozen cycles
    task automatic slow_step(input string tag, input logic [15:0] prev_ir, input logic [15:0] new_ir,
                             input logic hold_e, input logic busy_e);
        cen = 1'b0;
        tick();
        chk({tag, ".frozen"}, 32'(bus.ir), 32'(prev_ir));
        tick();
        chk({tag, ".frozen2"}, 32'(bus.ir), 32'(prev_ir));
        cen = 1'b1;
        tick();
        expect_out(tag, new_ir, 1'b1, hold_e, busy_e);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        cen            = 1'b1;
        bus.pc         = '0;
        bus.do_start   = 1'b0;
        bus.do_ni      = '0;
        bus.do_k       = '0;
        bus.redo_start = 1'b0;
        bus.flush      = 1'b0;

        tick();
        tick();
        expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            bus.pc = 16'(i);
            #1;
            chk("rom_addr", 32'(bus.rom_addr), 32'(i));
            tick();
            expect_out("straight", rom_word(i), 1'b1, 1'b0, 1'b0);
        end

        // do N=3 K=4
        bus.pc = 16'h0100;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd3;
        bus.do_k = 7'd4;
        tick();
        bus.do_start = 1'b0;
        expect_out("do34_issue", rom_word(32'h100), 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            bus.pc = 16'(32'h100 + i);
            tick();
            expect_out("do34_fill", rom_word(32'h100 + i), 1'b1, i == 3, 1'b1);
        end
        bus.pc = 16'h0104;
        for (int r = 0; r < 9; r++) begin
            tick();
            expect_out("do34_replay", rom_word(32'h101 + r % 3), 1'b1, r < 8, r < 8);
        end
        tick();
        expect_out("do34_resume", rom_word(32'h104), 1'b1, 1'b0, 1'b0);

        // K=1, N=15: fill only
        bus.pc = 16'h0200;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd15;
        bus.do_k = 7'd1;
        tick();
        bus.do_start = 1'b0;
        expect_out("k1_issue", rom_word(32'h200), 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            bus.pc = 16'(32'h200 + i);
            tick();
            expect_out("k1_fill", rom_word(32'h200 + i), 1'b1, 1'b0, i < 15);
        end
        bus.pc = 16'h0210;
        tick();
        expect_out("k1_resume", rom_word(32'h210), 1'b1, 1'b0, 1'b0);

        // N=0 and K=0 are ignored
        bus.pc = 16'h0300;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd0;
        bus.do_k = 7'd5;
        tick();
        expect_out("n0", rom_word(32'h300), 1'b1, 1'b0, 1'b0);
        bus.pc = 16'h0301;
        bus.do_ni = 4'd3;
        bus.do_k = 7'd0;
        tick();
        bus.do_start = 1'b0;
        expect_out("k0", rom_word(32'h301), 1'b1, 1'b0, 1'b0);

        // N=2 K=5, flush on the 4th replay word, do ignored during replay
        bus.pc = 16'h0400;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd2;
        bus.do_k = 7'd5;
        tick();
        bus.do_start = 1'b0;
        expect_out("fl_issue", rom_word(32'h400), 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            bus.pc = 16'(32'h400 + i);
            tick();
            expect_out("fl_fill", rom_word(32'h400 + i), 1'b1, i == 2, 1'b1);
        end
        bus.pc = 16'h0403;
        tick();
        expect_out("fl_rep1", rom_word(32'h401), 1'b1, 1'b1, 1'b1);
        bus.do_start = 1'b1;
        bus.do_ni = 4'd3;
        bus.do_k = 7'd2;
        tick();
        bus.do_start = 1'b0;
        expect_out("fl_rep2_do_ignored", rom_word(32'h402), 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("fl_rep3", rom_word(32'h401), 1'b1, 1'b1, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush.ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("flush.pc_hold", 32'(bus.pc_hold), 32'd0);
        chk("flush.cache_busy", 32'(bus.cache_busy), 32'd0);
        tick();
        expect_out("fl_resume", rom_word(32'h403), 1'b1, 1'b0, 1'b0);

        // do N=2 K=2, then redo K=3
        bus.pc = 16'h0500;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd2;
        bus.do_k = 7'd2;
        tick();
        bus.do_start = 1'b0;
        expect_out("rd_issue", rom_word(32'h500), 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            bus.pc = 16'(32'h500 + i);
            tick();
            expect_out("rd_fill", rom_word(32'h500 + i), 1'b1, i == 2, 1'b1);
        end
        bus.pc = 16'h0503;
        for (int r = 0; r < 2; r++) begin
            tick();
            expect_out("rd_replay", rom_word(32'h501 + r), 1'b1, r < 1, r < 1);
        end
        tick();
        expect_out("rd_idle", rom_word(32'h503), 1'b1, 1'b0, 1'b0);
        bus.pc = 16'h0504;
        bus.redo_start = 1'b1;
        bus.do_k = 7'd3;
        tick();
        bus.redo_start = 1'b0;
        bus.pc = 16'h0505;
`ifdef JTDSP16_REDO_EN
        expect_out("redo_issue", rom_word(32'h504), 1'b1, 1'b1, 1'b1);
        for (int r = 0; r < 6; r++) begin
            tick();
            expect_out("redo_replay", rom_word(32'h501 + r % 2), 1'b1, r < 5, r < 5);
        end
`else
        expect_out("redo_ignored", rom_word(32'h504), 1'b1, 1'b0, 1'b0);
`endif
        tick();
        expect_out("redo_resume", rom_word(32'h505), 1'b1, 1'b0, 1'b0);

        // do N=4 K=3 with cen high one cycle in three
        bus.pc = 16'h0600;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd4;
        bus.do_k = 7'd3;
        slow_step("cen_issue", rom_word(32'h505), rom_word(32'h600), 1'b0, 1'b1);
        bus.do_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.pc = 16'(32'h600 + i);
            slow_step("cen_fill", rom_word(32'h600 + i - 1), rom_word(32'h600 + i), i == 4, 1'b1);
        end
        bus.pc = 16'h0605;
        for (int r = 0; r < 8; r++) begin
            slow_step("cen_replay",
                      (r == 0) ? rom_word(32'h604) : rom_word(32'h601 + (r - 1) % 4),
                      rom_word(32'h601 + r % 4), r < 7, r < 7);
        end

        // reset in the middle of a fill
        bus.pc = 16'h0700;
        bus.do_start = 1'b1;
        bus.do_ni = 4'd4;
        bus.do_k = 7'd3;
        tick();
        bus.do_start = 1'b0;
        bus.pc = 16'h0701;
        tick();
        expect_out("rst_fill", rom_word(32'h701), 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        bus.pc = 16'h0702;
        tick();
        expect_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rst_resume", rom_word(32'h702), 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtdsp16_fetch.md
# jtdsp16_fetch

Instruction fetch stage directly downstream of the ROM address arithmetic unit. It drives the program ROM address from the program counter, registers the returned word into the instruction register, and implements the DSP16 instruction cache used by `do K` loops. During a loop, the first pass fills the cache from ROM and later passes replay it, while the block holds the program counter.

## Interface
Parameters:
- `CW`, default 4: cache index width. Cache depth is 2^CW−1 = 15 words.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cen`  in  1: clock enable; all state frozen when low.
- `pc`  in  16: current program address from the ROM AAU.
- `rom_addr`  out  16: program ROM address; equals `pc` combinationally.
- `rom_data`  in  16: ROM word for `rom_addr`, valid in the same cycle.
- `do_start`  in  1: decoded `do K` instruction, one `cen` cycle.
- `do_ni`  in  4: loop body length N, 1..15.
- `do_k`  in  7: iteration count K, 1..127.
- `redo_start`  in  1: decoded `redo K`; uses `do_k`. Ignored unless the macro is defined.
- `flush`  in  1: branch or interrupt; discards the pipeline word.
- `ir`  out  16: instruction register.
- `ir_valid`  out  1: `ir` holds an instruction to execute.
- `pc_hold`  out  1: high during replay; the AAU must not advance `pc`.
- `cache_busy`  out  1: state is not IDLE.

## Operation
- Storage: 15×16 cache RAM (not reset). Stored body length `n_st` (4 bits), loop counter `iter` (7 bits), index `idx` (4 bits).
- States: IDLE, FILL, REPLAY. Transitions occur only on `cen` edges.
- IDLE:
  - `ir <= rom_data`, `ir_valid <= 1`.
  - `do_start` with N≠0 and K≠0: latch `n_st=N`, `iter=K`, `idx=0`, then go to FILL.
  - `do_start` with N=0 or K=0: ignored.
- FILL:
  - Each cycle: `ir <= rom_data`, `cache[idx] <= rom_data`, `idx++`.
  - When the word at `idx==n_st−1` is written: if `iter==1`, go to IDLE; otherwise set `iter--`, `idx=0`, go to REPLAY.
- REPLAY:
  - Each cycle: `ir <= cache[idx]`, `ir_valid <= 1`, `pc_hold=1`.
  - At `idx==n_st−1`: set `idx=0`. If `iter==1`, go to IDLE; else `iter--`.
  - Total words issued per loop = N·K.
- `pc_hold` is combinational: equals (state==REPLAY).
- `flush` (any state, has priority over everything):
  - Next state IDLE, `ir_valid <= 0` for one cycle.
  - Cache contents and `n_st` are retained.
  - An aborted FILL leaves `n_st` equal to the count of words actually written (0 if none).
- `do_start` or `redo_start` while not IDLE: ignored.
- If `do_start` and `redo_start` arrive together, `do_start` wins.
- `iter` arithmetic is 7-bit unsigned and never wraps, because it is loaded ≥1 and the loop exits at 1.

## Timing
- Reset values: `ir=0`, `ir_valid=0`, `pc_hold=0`, `cache_busy=0`, state IDLE, `n_st=0`, `iter=0`, `idx=0`.
- Latency:
  - `pc` → `rom_addr`: 0 cycles.
  - `rom_data` → `ir`: 1 `cen` cycle.
  - The first replayed word appears in `ir` on the `cen` cycle after the last fill word.
- After the final replayed word, `pc_hold` drops in the same edge that returns the state to IDLE. The next `ir` is then `rom_data` at the held `pc` (loop end + 1).
- `rst` asserted mid-loop returns all registers to reset values on that edge. Cache RAM content is undefined afterwards.

## Configuration
- `JTDSP16_REDO_EN` defined:
  - In IDLE, `redo_start` with `n_st≠0` and `do_k≠0` sets `iter=do_k`, `idx=0`, and goes to REPLAY without a FILL pass.
  - The loop issues `n_st·do_k` words from the cache.
  - `redo_start` with `n_st=0` or `do_k=0` is ignored.
- Not defined: `redo_start` has no effect; the cache is used only for `do K`.

## Test plan
- **Reset and straight-line fetch:** hold `rst` 2 cycles; ROM word = address XOR 16'hA5A5; step `pc` 0..9 → `ir` tracks one cycle later, `ir_valid=1`, `pc_hold=0`.
- **do N=3, K=4:** 3 fill words from ROM then 9 replay words with `pc_hold=1`; `ir` sequence repeats 4 times; IDLE resumes at `pc`+3.
- **Edge values:**
  - K=1, N=15: fill only, no REPLAY, `pc_hold` never high.
  - N=0 or K=0: no state change.
- **Flush mid-replay** (N=2, K=5, flush on the 4th replay word): `ir_valid=0` for one cycle, then ROM fetch resumes; `do_start` during REPLAY is ignored.
- **With `JTDSP16_REDO_EN`:** after a do N=2 K=2, `redo_start` with `do_k=3` → 6 cached words, no ROM reads used, `pc_hold` high for 6 cycles. Without the macro, the same stimulus gives no change.
- **`cen` toggling 1-of-3 during a do N=4 K=3 loop:** identical `ir` sequence on `cen` cycles; `rst` mid-FILL → all outputs return to their reset values.
